// File: rtl/udp_master_pkg.sv
// Shared constants for the UDP transmit datapath, used by the serializer and
// the downstream byte-wide framer.
package udp_master_pkg;

  localparam int UDP_BYTE_W = 8;

endpackage

// File: rtl/axis_byte_serializer_if.sv
// Command, upstream-word and downstream-byte handshakes of the byte serializer.
// The serializer takes the master view; the FIFO/framer side takes the slave view.
interface axis_byte_serializer_if
  import udp_master_pkg::*;
#(
  parameter int T_DATA_WIDTH = 32,
  parameter int LEN_WIDTH    = 16
);

  logic [LEN_WIDTH-1:0]    cmd_len_i;
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic [T_DATA_WIDTH-1:0] s_data_i;
  logic                    s_valid_i;
  logic                    s_ready_o;
  logic [UDP_BYTE_W-1:0]   m_data_o;
  logic                    m_valid_o;
  logic                    m_last_o;
  logic                    m_ready_i;
  logic                    busy_o;

  modport master (
    input  cmd_len_i, cmd_valid_i, s_data_i, s_valid_i, m_ready_i,
    output cmd_ready_o, s_ready_o, m_data_o, m_valid_o, m_last_o, busy_o
  );

  modport slave (
    output cmd_len_i, cmd_valid_i, s_data_i, s_valid_i, m_ready_i,
    input  cmd_ready_o, s_ready_o, m_data_o, m_valid_o, m_last_o, busy_o
  );

endinterface

// File: rtl/axis_byte_serializer.sv
// Splits FIFO words into an MSB-first byte stream of exactly cmd_len bytes,
// popping only the words that packet needs and flagging the final byte.
module axis_byte_serializer
  import udp_master_pkg::*;
#(
  parameter int T_DATA_WIDTH = 32,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  axis_byte_serializer_if.master bus
);

  localparam int BYTES = T_DATA_WIDTH / UDP_BYTE_W;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t                  state;
  logic [LEN_WIDTH-1:0]    rem;
  logic [IDX_W-1:0]        byte_idx;
  logic [T_DATA_WIDTH-1:0] shreg;

  // The output byte is always the top of the shift register, so it is held
  // stable for free while the downstream stalls.
  assign bus.m_data_o = shreg[T_DATA_WIDTH-1 -: UDP_BYTE_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rem             <= '0;
      byte_idx        <= '0;
      shreg           <= '0;
      bus.cmd_ready_o <= 1'b1;
      bus.s_ready_o   <= 1'b0;
      bus.m_valid_o   <= 1'b0;
      bus.m_last_o    <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length commands are swallowed here without touching the FIFO.
          if (bus.cmd_valid_i && bus.cmd_ready_o && (bus.cmd_len_i != '0)) begin
            rem             <= bus.cmd_len_i;
            state           <= LOAD;
            bus.cmd_ready_o <= 1'b0;
            bus.s_ready_o   <= 1'b1;
            bus.busy_o      <= 1'b1;
          end
        end

        LOAD: begin
          if (bus.s_valid_i && bus.s_ready_o) begin
            shreg         <= bus.s_data_i;
            byte_idx      <= '0;
            state         <= SHIFT;
            bus.s_ready_o <= 1'b0;
            bus.m_valid_o <= 1'b1;
            bus.m_last_o  <= (rem == LEN_WIDTH'(1));
          end
        end

        SHIFT: begin
          if (bus.m_valid_o && bus.m_ready_i) begin
            rem          <= rem - LEN_WIDTH'(1);
            shreg        <= shreg << UDP_BYTE_W;
            byte_idx     <= byte_idx + IDX_W'(1);
            bus.m_last_o <= (rem == LEN_WIDTH'(2));
            // Packet end wins over word end: leftover bytes of the word are dropped.
            if (rem == LEN_WIDTH'(1)) begin
              state           <= IDLE;
              bus.m_valid_o   <= 1'b0;
              bus.m_last_o    <= 1'b0;
              bus.cmd_ready_o <= 1'b1;
              bus.busy_o      <= 1'b0;
            end else if (byte_idx == LAST_IDX) begin
              state         <= LOAD;
              bus.m_valid_o <= 1'b0;
              bus.m_last_o  <= 1'b0;
              bus.s_ready_o <= 1'b1;
            end
          end
        end

        default: begin
          state           <= IDLE;
          bus.cmd_ready_o <= 1'b1;
          bus.s_ready_o   <= 1'b0;
          bus.m_valid_o   <= 1'b0;
          bus.m_last_o    <= 1'b0;
          bus.busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_byte_serializer.sv
// Randomized bench for axis_byte_serializer: a word-queue FIFO model feeds the
// DUT and every emitted byte is checked against the MSB-first slice of that queue.
module tb_axis_byte_serializer;

  localparam int T_DATA_WIDTH = 32;
  localparam int LEN_WIDTH    = 16;
  localparam int BYTES        = T_DATA_WIDTH / 8;

  logic clk;
  logic reset_n;

  int unsigned compareCount;
  int unsigned mismatchCount;

  logic [T_DATA_WIDTH-1:0] wordQ[$];

  axis_byte_serializer_if #(.T_DATA_WIDTH(T_DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

  axis_byte_serializer #(.T_DATA_WIDTH(T_DATA_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".cmdReady"}, 32'(bus.cmd_ready_o), 1);
    checkOutput({tag, ".sReady"},   32'(bus.s_ready_o),   0);
    checkOutput({tag, ".mValid"},   32'(bus.m_valid_o),   0);
    checkOutput({tag, ".mLast"},    32'(bus.m_last_o),    0);
    checkOutput({tag, ".mData"},    32'(bus.m_data_o),    0);
    checkOutput({tag, ".busy"},     32'(bus.busy_o),      0);
  endtask

  // Fill the FIFO model with the packet's words plus one extra word that must never be popped.
  task automatic loadWords(input int len, input logic [T_DATA_WIDTH-1:0] w0, input logic [T_DATA_WIDTH-1:0] w1);
    int needWords;
    needWords = (len + BYTES - 1) / BYTES;
    wordQ = {};
    for (int i = 0; i <= needWords; i++) begin
      if (i == 0) wordQ.push_back(w0);
      else if (i == 1) wordQ.push_back(w1);
      else wordQ.push_back($urandom);
    end
  endtask

  // mode 0: m_ready always high, 1: toggles each cycle, 2: random on both sides.
  task automatic applyStimulus(input int len, input int mode, input int starveIn,
                               input int abortAfter, input bit checkLatency);
    logic [7:0] expBytes[$];
    int needWords, pops, byteIdx, wIdx, sinceCmd, starve;
    bit firstSeen, stalled, done;
    logic [7:0] heldData;
    logic heldLast;

    expBytes = {};
    for (int i = 0; i < len; i++)
      expBytes.push_back(8'((wordQ[i / BYTES] >> (8 * (BYTES - 1 - (i % BYTES)))) & 32'hFF));
    needWords = (len + BYTES - 1) / BYTES;
    pops = 0; byteIdx = 0; wIdx = 0; sinceCmd = 0; starve = starveIn;
    firstSeen = 0; stalled = 0; done = 0; heldData = '0; heldLast = 1'b0;

    @(negedge clk);
    checkOutput("cmdReadyBeforeCmd", 32'(bus.cmd_ready_o), 1);
    bus.cmd_len_i   = LEN_WIDTH'(len);
    bus.cmd_valid_i = 1'b1;
    bus.s_valid_i   = 1'b0;
    bus.m_ready_i   = 1'b0;

    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      bus.cmd_len_i   = LEN_WIDTH'($urandom);
      sinceCmd++;

      if (stalled && bus.m_valid_o) begin
        checkOutput("stallData", 32'(bus.m_data_o), 32'(heldData));
        checkOutput("stallLast", 32'(bus.m_last_o), 32'(heldLast));
      end
      if (bus.m_valid_o && !firstSeen) begin
        firstSeen = 1;
        if (checkLatency) checkOutput("firstByteLatency", 32'(sinceCmd), 2);
      end

      if (starve > 0 && bus.s_ready_o) begin
        bus.s_valid_i = 1'b0;
        starve--;
        checkOutput("starveMValid", 32'(bus.m_valid_o), 0);
        checkOutput("starveSReady", 32'(bus.s_ready_o), 1);
      end else if (wIdx < wordQ.size()) begin
        bus.s_valid_i = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        bus.s_valid_i = 1'b0;
      end
      bus.s_data_i = bus.s_valid_i ? wordQ[wIdx] : T_DATA_WIDTH'($urandom);

      case (mode)
        0:       bus.m_ready_i = 1'b1;
        1:       bus.m_ready_i = ((cyc % 2) == 0);
        default: bus.m_ready_i = ($urandom_range(0, 2) != 0);
      endcase

      if (bus.s_valid_i && bus.s_ready_o) begin
        pops++;
        wIdx++;
      end

      stalled  = bus.m_valid_o && !bus.m_ready_i;
      heldData = bus.m_data_o;
      heldLast = bus.m_last_o;

      if (bus.m_valid_o && bus.m_ready_i) begin
        if (byteIdx < len) begin
          checkOutput($sformatf("byte%0d", byteIdx), 32'(bus.m_data_o), 32'(expBytes[byteIdx]));
          checkOutput($sformatf("last%0d", byteIdx), 32'(bus.m_last_o), 32'(byteIdx == len - 1));
        end else begin
          checkOutput("extraByte", 1, 0);
        end
        byteIdx++;
        if (byteIdx == len || byteIdx == abortAfter) done = 1;
      end
    end

    if (!done) begin
      checkOutput("packetTimeout", 0, 1);
    end else if (abortAfter == 0) begin
      @(negedge clk);
      bus.s_valid_i = 1'b0;
      checkOutput("cmdReadyAfterLast", 32'(bus.cmd_ready_o), 1);
      checkOutput("busyAfterLast",     32'(bus.busy_o),      0);
      checkOutput("sReadyAfterLast",   32'(bus.s_ready_o),   0);
      checkOutput("mValidAfterLast",   32'(bus.m_valid_o),   0);
      checkOutput("popCount",          32'(pops),            32'(needWords));
    end
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    reset_n         = 1'b0;
    bus.cmd_len_i   = '0;
    bus.cmd_valid_i = 1'b0;
    bus.s_data_i    = '0;
    bus.s_valid_i   = 1'b0;
    bus.m_ready_i   = 1'b0;

    #12;
    checkResetOutputs("resetState");
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] basic packet, partial last word");
    loadWords(6, 32'h11223344, 32'h55667788);
    applyStimulus(6, 0, 0, 0, 1'b0);

    $display("[TB] exact single word");
    loadWords(4, 32'hA1B2C3D4, 32'h0);
    applyStimulus(4, 0, 0, 0, 1'b1);

    $display("[TB] zero-length command");
    @(negedge clk);
    bus.cmd_len_i   = '0;
    bus.cmd_valid_i = 1'b1;
    bus.s_valid_i   = 1'b1;
    bus.s_data_i    = 32'h0BADF00D;
    bus.m_ready_i   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cmd_valid_i = 1'b0;
      checkOutput("zeroLenSReady",   32'(bus.s_ready_o),   0);
      checkOutput("zeroLenMValid",   32'(bus.m_valid_o),   0);
      checkOutput("zeroLenCmdReady", 32'(bus.cmd_ready_o), 1);
    end
    bus.s_valid_i = 1'b0;

    $display("[TB] one-byte packet");
    loadWords(1, 32'hDEADBEEF, 32'h0);
    applyStimulus(1, 0, 0, 0, 1'b1);

    $display("[TB] output backpressure");
    loadWords(8, $urandom, $urandom);
    applyStimulus(8, 1, 0, 0, 1'b0);

    $display("[TB] upstream starvation");
    loadWords(6, $urandom, $urandom);
    applyStimulus(6, 0, 5, 0, 1'b0);

    $display("[TB] mid-packet reset");
    loadWords(10, $urandom, $urandom);
    applyStimulus(10, 0, 0, 3, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetOutputs("midReset");
    @(negedge clk);
    checkResetOutputs("midResetHeld");
    bus.s_valid_i = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("cmdReadyAfterReset", 32'(bus.cmd_ready_o), 1);
    loadWords(4, $urandom, $urandom);
    applyStimulus(4, 0, 0, 0, 1'b1);

    $display("[TB] randomized packets");
    for (int p = 0; p < 15; p++) begin
      int len;
      len = $urandom_range(1, 24);
      loadWords(len, $urandom, $urandom);
      applyStimulus(len, 2, $urandom_range(0, 2), 0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/axis_byte_serializer.md
# axis_byte_serializer

Converts the word stream from the UDP payload `axis_fifo` into a byte-wide AXI-Stream for the MAC transmit path. Each command gives a packet length in bytes. The block pops exactly ceil(len/BYTES) words from the FIFO, emits exactly len bytes in network (MSB-first) order, and marks the final byte with `m_last_o`. It sits directly downstream of the payload FIFO's read port and upstream of the byte-wide framing logic.

## Interface
- `T_DATA_WIDTH`, default 32: upstream word width; must be a multiple of 8. BYTES = T_DATA_WIDTH/8.
- `LEN_WIDTH`, default 16: width of the byte-length command and counter.
- `clk`  input  1: single clock, rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `cmd_len_i`  input  LEN_WIDTH: packet length in bytes.
- `cmd_valid_i`  input  1: command valid.
- `cmd_ready_o`  output  1: command accepted when high with `cmd_valid_i`.
- `s_data_i`  input  T_DATA_WIDTH: word from the FIFO (`m_data_o` of `axis_fifo`).
- `s_valid_i`  input  1: word valid.
- `s_ready_o`  output  1: word pop strobe to the FIFO.
- `m_data_o`  output  8: output byte.
- `m_valid_o`  output  1: byte valid.
- `m_last_o`  output  1: final byte of packet.
- `m_ready_i`  input  1: downstream ready.
- `busy_o`  output  1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, LOAD, SHIFT. All outputs are registered.
- **IDLE**
  - `cmd_ready_o` = 1; `s_ready_o` = 0; `m_valid_o` = 0.
  - Command handshake with len > 0: latch `rem` = len, go to LOAD.
  - Command handshake with len = 0: consume and discard the command, stay in IDLE. No word is popped and no byte is emitted.
- **LOAD**
  - `s_ready_o` = 1; `cmd_ready_o` = 0; `m_valid_o` = 0.
  - On the `s` handshake: capture the word into the shift register, set `byte_idx` = 0, go to SHIFT.
  - With no `s_valid_i`, wait in LOAD indefinitely.
- **SHIFT**
  - `m_valid_o` = 1.
  - `m_data_o` = the current top byte. Byte 0 is `s_data_i[T_DATA_WIDTH-1 -: 8]`.
  - `m_last_o` = (`rem` == 1).
  - On each `m` handshake: `rem` decrements, the shift register shifts left by 8, `byte_idx` increments.
  - After the handshake on the byte with `rem` == 1: go to IDLE. Remaining bytes of the current word are discarded.
  - Otherwise, after the handshake on the byte with `byte_idx` == BYTES-1: go to LOAD.
  - Otherwise: stay in SHIFT.
- While `m_valid_o` = 1 and `m_ready_i` = 0, `m_data_o` and `m_last_o` hold stable.
- Width rules:
  - `rem` is LEN_WIDTH bits; the maximum packet is 2^LEN_WIDTH-1 bytes.
  - `byte_idx` is max(1, $clog2(BYTES)) bits.
  - Words popped per packet = ceil(len/BYTES). The FIFO is never over-read.
- Upstream `s_valid_i` while not in LOAD is ignored; `s_ready_o` = 0 guarantees no pop.

## Timing
- Reset values:
  - Outputs: `cmd_ready_o` = 1, `s_ready_o` = 0, `m_valid_o` = 0, `m_last_o` = 0, `m_data_o` = 0, `busy_o` = 0.
  - Internal: state IDLE, `rem` = 0, `byte_idx` = 0.
- Command handshake at edge N: `s_ready_o` = 1 from N+1.
- Word handshake at edge M: `m_valid_o` = 1 with byte 0 from M+1.
- The LOAD state costs one bubble cycle per word. With no backpressure:
  - Sustained rate is BYTES bytes per BYTES+1 cycles.
  - Packet latency from command to first byte is 2 cycles.
- Handshake on the last byte at edge L: `cmd_ready_o` = 1 from L+1. A new command is accepted at L+1 at the earliest.
- Reset asserted mid-packet:
  - All outputs return to reset values immediately (asynchronous).
  - The partial packet is abandoned, with no `m_last_o`.
  - Flushing any unread words of that packet from the FIFO is the parent's responsibility; the FIFO is normally reset on the same `reset_n`.

## Structure
- The state enum (IDLE/LOAD/SHIFT) is a typedef local to the module.
- BYTES and the `byte_idx` width are localparams derived from T_DATA_WIDTH.
- The shared `udp_master_pkg` gains one constant, `UDP_BYTE_W` = 8, used here and by the downstream framer.
- There is no sub-module. The `axis_fifo` instance and its connection live in the parent.

## Test plan
- **Basic packet, partial last word:** len=6; words 0x11223344, 0x55667788; `m_ready_i`=1.
  - Required: bytes 11 22 33 44 55 66, `m_last_o` only on 66; exactly 2 pops; `cmd_ready_o` high 1 cycle after the 66 handshake.
- **Exact single word:** len=4; word 0xA1B2C3D4.
  - Required: bytes A1 B2 C3 D4, last on D4; 1 pop; first byte 2 cycles after the command handshake.
- **Zero and one byte:** len=0, then len=1 with word 0xDEADBEEF.
  - Required: no pop and no output for len=0; then single byte DE with `m_last_o`=1, 1 pop.
- **Output backpressure:** len=8; `m_ready_i` toggles 1/0 each cycle.
  - Required: `m_data_o`/`m_last_o` stable during stalls; sequence intact; exactly 2 pops.
- **Upstream starvation:** `s_valid_i` low for 5 cycles in LOAD.
  - Required: `m_valid_o`=0 and `s_ready_o`=1 throughout; resumes correctly once a word arrives.
- **Mid-packet reset:** `reset_n` pulsed low after the 3rd byte of a len=10 packet.
  - Required: all outputs at reset values during reset; `cmd_ready_o`=1 after release; the next len=4 packet is correct.
